// File: rtl/fir_coeff_loader.sv
// Coefficient-load initiator for the symmetric FIR: assembles a byte stream into C-bit words,
// writes them to coefficient addresses 0..NC-1, then checks a trailing XOR checksum byte.
module fir_coeff_loader #(
  parameter int unsigned ORD = 256,
  parameter int unsigned C   = 16,
  parameter int unsigned GAP = 1,
  localparam int unsigned NC = (ORD + 1) / 2,
  localparam int unsigned AW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          c_WE,
  output logic [C-1:0]  c_in,
  output logic [AW-1:0] c_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned BYTES = C / 8;
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned GW    = (GAP > 1) ? $clog2(GAP) : 1;
  // Partial word holds only the bytes received before the final one of a word.
  localparam int unsigned WW    = (C > 8) ? C - 8 : 1;

  typedef enum logic [2:0] {StIdle, StRecv, StWrite, StWait, StChk} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] word_q;
  logic [C-1:0]  c_in_q;
  logic [AW-1:0] idx_q, c_addr_q;
  logic [BW-1:0] byte_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [7:0]    csum_q;
  logic          done_q, err_q;

  logic          xfer, last_byte, last_idx, gap_end;
  logic [C-1:0]  word_next;

  assign xfer      = in_valid && in_ready;
  assign last_byte = (32'(byte_cnt_q) == BYTES - 1);
  assign last_idx  = (32'(idx_q) == NC - 1);
  assign gap_end   = (32'(gap_cnt_q) == GAP - 1);

  if (C > 8) begin : g_wide
    assign word_next = {word_q, in_data};
  end else begin : g_byte
    assign word_next = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRecv;
      StRecv:  if (xfer && last_byte) state_d = StWrite;
      StWrite: begin
        if (last_idx)     state_d = StChk;
        else if (GAP > 0) state_d = StWait;
        else              state_d = StRecv;
      end
      StWait:  if (gap_end) state_d = StRecv;
      StChk:   if (xfer) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StRecv) || (state_q == StChk);
    c_WE     = (state_q == StWrite);
    busy     = (state_q != StIdle);
  end

  assign c_in   = c_in_q;
  assign c_addr = c_addr_q;
  assign done   = done_q;
  assign err    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      c_in_q     <= '0;
      idx_q      <= '0;
      c_addr_q   <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      csum_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            idx_q      <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            err_q      <= 1'b0;
          end
        end
        StRecv: begin
          if (xfer) begin
            csum_q <= csum_q ^ in_data;
            word_q <= word_next[WW-1:0];
            if (last_byte) begin
              // c_in/c_addr are loaded here so they are valid during WRITE and hold after.
              byte_cnt_q <= '0;
              c_in_q     <= word_next;
              c_addr_q   <= idx_q;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        StWrite: begin
          gap_cnt_q <= '0;
          if (!last_idx) idx_q <= idx_q + 1'b1;
        end
        StWait: gap_cnt_q <= gap_cnt_q + 1'b1;
        StChk: begin
          if (xfer) begin
            err_q  <= (in_data != csum_q);
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: a default instance (C=16, GAP=1) and a C=24, GAP=0 instance,
// driven through a shared byte driver with randomized valid, checked against a stream model.
module tb_fir_coeff_loader;

  localparam int unsigned B_ORD = 7;
  localparam int unsigned B_C   = 24;
  localparam int unsigned B_GAP = 0;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic       clk = 1'b0;
  logic       rst, start, in_valid, sel;
  logic [7:0] in_data;

  logic        a_in_ready, a_c_we, a_busy, a_done, a_err;
  logic [15:0] a_c_in;
  logic [6:0]  a_c_addr;
  logic        b_in_ready, b_c_we, b_busy, b_done, b_err;
  logic [23:0] b_c_in;
  logic [1:0]  b_c_addr;

  logic        rdy, m_we, m_busy, m_done, m_err;
  logic [31:0] m_addr, m_data;

  int tests_run = 0;
  int fails     = 0;

  fir_coeff_loader u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start && !sel),
    .in_valid (in_valid && !sel),
    .in_data  (in_data),
    .in_ready (a_in_ready),
    .c_WE     (a_c_we),
    .c_in     (a_c_in),
    .c_addr   (a_c_addr),
    .busy     (a_busy),
    .done     (a_done),
    .err      (a_err)
  );

  fir_coeff_loader #(.ORD(B_ORD), .C(B_C), .GAP(B_GAP)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start && sel),
    .in_valid (in_valid && sel),
    .in_data  (in_data),
    .in_ready (b_in_ready),
    .c_WE     (b_c_we),
    .c_in     (b_c_in),
    .c_addr   (b_c_addr),
    .busy     (b_busy),
    .done     (b_done),
    .err      (b_err)
  );

  assign rdy    = sel ? b_in_ready : a_in_ready;
  assign m_we   = sel ? b_c_we : a_c_we;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_err  = sel ? b_err : a_err;
  assign m_addr = sel ? 32'(b_c_addr) : 32'(a_c_addr);
  assign m_data = sel ? 32'(b_c_in) : 32'(a_c_in);

  always #5 clk = ~clk;

  // Write/done monitor on the selected instance.
  word_q_t wq_addr, wq_data;
  time     wq_time[$];
  int      b2b = 0;
  int      done_cnt = 0;
  time     done_time, last_acc_time;
  logic    done_err, done_busy;
  logic    prev_we = 1'b0;

  always @(negedge clk) begin
    if (m_we) begin
      wq_addr.push_back(m_addr);
      wq_data.push_back(m_data);
      wq_time.push_back($time);
      if (prev_we) b2b++;
    end
    prev_we = m_we;
    if (m_done) begin
      done_cnt++;
      done_time = $time;
      done_err  = m_err;
      done_busy = m_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    wq_addr.delete();
    wq_data.delete();
    wq_time.delete();
    b2b      = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Model: each word is sent MSB byte first, followed by the XOR of all bytes (or its inverse).
  task automatic make_stream(input word_q_t coefs, input int nbytes, input bit good,
                             output byte_q_t s);
    logic [7:0] x, v;
    x = 8'h00;
    s = {};
    foreach (coefs[i]) begin
      for (int b = nbytes - 1; b >= 0; b--) begin
        v = coefs[i][8*b +: 8];
        s.push_back(v);
        x ^= v;
      end
    end
    s.push_back(good ? x : ~x);
  endtask

  task automatic send_stream(input byte_q_t s, input int lo, input int hi, input int duty);
    int  idx, budget;
    bit  v, acc;
    idx    = lo;
    budget = 20 * (hi - lo + 1) + 100;
    while (idx <= hi && budget > 0) begin
      @(negedge clk);
      v        = (duty >= 100) || ($urandom_range(99) < duty);
      in_valid = v;
      in_data  = v ? s[idx] : 8'($urandom);
      acc      = v && rdy;
      if (acc) last_acc_time = $time;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget--;
    end
    in_valid = 1'b0;
    check("stream_progress", idx, hi + 1);
  endtask

  task automatic compare_writes(input word_q_t exp, input bit spacing);
    check("wr_count", wq_data.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wq_data.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), wq_addr[i], i);
      check($sformatf("wr_data[%0d]", i), wq_data[i], exp[i]);
      if (spacing && i > 0) check($sformatf("wr_gap[%0d]", i), 32'(wq_time[i] - wq_time[i-1]), 40);
    end
    check("no_b2b_we", b2b, 0);
  endtask

  task automatic check_done(input logic e);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("done_latency", 32'(done_time - last_acc_time), 10);
    check("done_err", done_err, e);
    check("done_busy", done_busy, 1'b0);
  endtask

  byte_q_t    s;
  word_q_t    ca, cb, e61;
  logic [7:0] kb;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_c_we", a_c_we, 0);
    check("rst_c_in", a_c_in, 0);
    check("rst_c_addr", a_c_addr, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    check("rst_b_c_in", b_c_in, 0);

    // Valid bytes offered in IDLE are not consumed.
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      check("idle_in_ready", a_in_ready, 0);
    end
    in_valid = 1'b0;
    check("idle_busy", a_busy, 0);
    check("idle_no_writes", wq_data.size(), 0);

    for (int k = 0; k < 128; k++) begin
      kb = k[7:0];
      ca.push_back({16'h0000, kb, ~kb});
    end

    // Full load, continuous valid, correct checksum.
    clear_mon();
    pulse_start();
    check("start_busy", a_busy, 1);
    check("start_in_ready", a_in_ready, 1);
    make_stream(ca, 2, 1'b1, s);
    send_stream(s, 0, s.size() - 1, 100);
    check_done(1'b0);
    compare_writes(ca, 1'b1);
    check("hold_c_in", a_c_in, ca[127]);
    check("hold_c_addr", a_c_addr, 127);

    // Same stream with a wrong checksum: writes still happen, err sticks until next start.
    clear_mon();
    pulse_start();
    make_stream(ca, 2, 1'b0, s);
    send_stream(s, 0, s.size() - 1, 100);
    check_done(1'b1);
    compare_writes(ca, 1'b1);
    repeat (10) @(negedge clk);
    check("err_sticky", a_err, 1);
    clear_mon();
    pulse_start();
    check("err_cleared", a_err, 0);

    // Random valid gaps on the load just started.
    make_stream(ca, 2, 1'b1, s);
    send_stream(s, 0, s.size() - 1, 50);
    check_done(1'b0);
    compare_writes(ca, 1'b0);

    // Start mid-load is ignored; reset after address 60 abandons the load.
    clear_mon();
    pulse_start();
    send_stream(s, 0, 79, 100);
    pulse_start();
    check("busy_after_ignored_start", a_busy, 1);
    send_stream(s, 80, 121, 100);
    @(negedge clk);
    check("we_addr60", a_c_we, 1);
    check("addr60", a_c_addr, 60);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", a_in_ready, 0);
    check("midrst_c_we", a_c_we, 0);
    check("midrst_c_in", a_c_in, 0);
    check("midrst_c_addr", a_c_addr, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_err", a_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_busy", a_busy, 0);
    check("postrst_done_count", done_cnt, 0);
    for (int i = 0; i < 61; i++) e61.push_back(ca[i]);
    compare_writes(e61, 1'b0);

    clear_mon();
    pulse_start();
    send_stream(s, 0, s.size() - 1, 100);
    check_done(1'b0);
    compare_writes(ca, 1'b1);

    // C=24, GAP=0 instance: 3 bytes per word, MSB first, a write every 4 cycles.
    sel = 1'b1;
    cb.push_back(32'h0012_3456);
    repeat (3) cb.push_back({8'h00, 24'($urandom)});
    clear_mon();
    pulse_start();
    check("b_start_busy", b_busy, 1);
    make_stream(cb, 3, 1'b1, s);
    check("b_first_byte", s[0], 8'h12);
    send_stream(s, 0, s.size() - 1, 100);
    check_done(1'b0);
    compare_writes(cb, 1'b1);
    check("a_idle_during_b", a_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
